// File: rtl/cache_fill_pkg.sv
// rtl/cache_fill_pkg.sv - shared types and geometry for the cache miss fill handler
package cache_fill_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_TAG  = 2'd2
    } fill_state_e;

    localparam int unsigned WORDS_PER_BLOCK = 8;
    localparam int unsigned OFFSET_BITS     = 4;
    localparam int unsigned WORD_BYTES      = 2;

    // Byte offset of a word inside a block; the block base is aligned so this never carries.
    function automatic logic [OFFSET_BITS-1:0] word_offset(input logic [2:0] idx);
        return OFFSET_BITS'(idx) * OFFSET_BITS'(WORD_BYTES);
    endfunction

endpackage

// File: rtl/cache_fill_fsm_counter.sv
// rtl/cache_fill_fsm_counter.sv - 4-bit saturating word counter used for issue and receive
module fill_counter
    import cache_fill_pkg::*;
#(
    parameter int unsigned MAX = WORDS_PER_BLOCK
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] cnt
);

    logic [3:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != 4'(MAX))) begin
            cnt_q <= cnt_q + 4'd1;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/cache_fill_fsm.sv
// rtl/cache_fill_fsm.sv - miss handler: eight pipelined word reads, data writes, one tag write
module cache_fill_fsm
    import cache_fill_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 16,
    parameter int unsigned WORDS_PER_BLOCK = cache_fill_pkg::WORDS_PER_BLOCK
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  miss_detected,
    input  logic [ADDR_WIDTH-1:0] miss_address,
    input  logic                  memory_data_valid,
    input  logic [15:0]           memory_data_out,
    output logic                  fsm_busy,
    output logic                  mem_en,
    output logic [ADDR_WIDTH-1:0] memory_address,
    output logic                  write_data_array,
    output logic [ADDR_WIDTH-1:0] cache_addr,
    output logic [15:0]           cache_data_in,
    output logic                  write_tag_array
);

    fill_state_e           state_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [3:0]            issue_cnt;
    logic [3:0]            recv_cnt;
    logic                  start_fill;
    logic                  in_fill;
    logic                  recv_accept;

    assign in_fill     = (state_q == ST_FILL);
    assign start_fill  = (state_q == ST_IDLE) && miss_detected;
    assign recv_accept = in_fill && memory_data_valid && (recv_cnt < 4'(WORDS_PER_BLOCK));

    fill_counter #(.MAX(WORDS_PER_BLOCK)) u_issue_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_fill),
        .inc   (in_fill),
        .cnt   (issue_cnt)
    );

    fill_counter #(.MAX(WORDS_PER_BLOCK)) u_recv_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_fill),
        .inc   (recv_accept),
        .cnt   (recv_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (miss_detected) begin
                        state_q <= ST_FILL;
                        base_q  <= {miss_address[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                    end
                end
                ST_FILL: begin
                    // Tag write waits for the last data word so way selection stays stable.
                    if (recv_accept && (recv_cnt == 4'(WORDS_PER_BLOCK - 1))) begin
                        state_q <= ST_TAG;
                    end
                end
                ST_TAG:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_en           = in_fill && (issue_cnt < 4'(WORDS_PER_BLOCK));
        memory_address   = '0;
        write_data_array = recv_accept;
        cache_addr       = '0;
        cache_data_in    = '0;
        write_tag_array  = (state_q == ST_TAG);
        // In IDLE the stall follows the miss line directly so the pipeline freezes immediately.
        fsm_busy         = (state_q != ST_IDLE) || (miss_detected && rst_n);

        if (mem_en) begin
            memory_address = base_q + ADDR_WIDTH'(word_offset(issue_cnt[2:0]));
        end
        if (in_fill) begin
            cache_addr = base_q + ADDR_WIDTH'(word_offset(recv_cnt[2:0]));
        end else if (state_q == ST_TAG) begin
            cache_addr = base_q;
        end
        if (recv_accept) begin
            cache_data_in = memory_data_out;
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb/tb_cache_fill_fsm.sv - directed self-checking bench for cache_fill_fsm
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        memory_data_valid;
    logic [15:0] memory_data_out;
    logic        fsm_busy;
    logic        mem_en;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [15:0] cache_addr;
    logic [15:0] cache_data_in;
    logic        write_tag_array;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cache_fill_fsm #(.ADDR_WIDTH(16), .WORDS_PER_BLOCK(8)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data_valid (memory_data_valid),
        .memory_data_out   (memory_data_out),
        .fsm_busy          (fsm_busy),
        .mem_en            (mem_en),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .cache_addr        (cache_addr),
        .cache_data_in     (cache_data_in),
        .write_tag_array   (write_tag_array)
    );

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic busy, input logic en,
                           input logic [15:0] maddr, input logic wr, input logic [15:0] caddr,
                           input logic [15:0] cdata, input logic tagw);
        chk1 ({tag, " busy"},  fsm_busy,         busy);
        chk1 ({tag, " mem_en"}, mem_en,          en);
        chk16({tag, " maddr"}, memory_address,   maddr);
        chk1 ({tag, " wr"},    write_data_array, wr);
        chk16({tag, " caddr"}, cache_addr,       caddr);
        chk16({tag, " cdata"}, cache_data_in,    cdata);
        chk1 ({tag, " tagw"},  write_tag_array,  tagw);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        miss_detected     = 1'b0;
        miss_address      = 16'h0000;
        memory_data_valid = 1'b0;
        memory_data_out   = 16'h0000;
    endtask

    // One complete fill. Word w returns at cycle 5+w, shifted by gap cycles after word 2.
    task automatic run_fill(input string name, input logic [15:0] addr, input logic [15:0] alt,
                            input logic [15:0] base, input int gap, input bit drop, input bit extra);
        int          tag_c;
        int          got;
        int          nwr;
        int          ntag;
        int          w;
        logic [15:0] d;
        logic        e_en;
        logic [15:0] e_maddr;
        logic [15:0] e_caddr;
        tag_c = 13 + gap;
        got   = 0;
        nwr   = 0;
        ntag  = 0;
        for (int c = 0; c <= tag_c + 1; c++) begin
            w = -1;
            if (c >= 5 && c <= 7) w = c - 5;
            else if (c >= 8 + gap && c <= 12 + gap) w = c - 5 - gap;
            d = 16'h5A00 + 16'(w);
            miss_detected     = drop ? (c < 2) : (c == 0);
            miss_address      = (c == 0) ? addr : alt;
            memory_data_valid = (w >= 0) || (extra && c == tag_c);
            memory_data_out   = (w >= 0) ? d : 16'hBAD0;
            #3;
            e_en    = (c >= 1 && c <= 8);
            e_maddr = e_en ? base + 16'(2 * (c - 1)) : 16'h0000;
            if (c == tag_c) e_caddr = base;
            else if (c >= 1 && c < tag_c) e_caddr = base + 16'(2 * got);
            else e_caddr = 16'h0000;
            chk_all($sformatf("%s c%0d", name, c), c <= tag_c, e_en, e_maddr, w >= 0,
                    e_caddr, (w >= 0) ? d : 16'h0000, c == tag_c);
            if (write_data_array) nwr++;
            if (write_tag_array) ntag++;
            if (w >= 0) got++;
            tick();
        end
        chk_int({name, " data writes"}, nwr, 8);
        chk_int({name, " tag writes"}, ntag, 1);
        idle_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        miss_detected = 1'b1;
        tick();
        #2;
        chk_all("reset", 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
        idle_inputs();
        tick();
        rst_n = 1'b1;
        tick();

        // Spurious return while idle must not write the cache.
        memory_data_valid = 1'b1;
        memory_data_out   = 16'hEEEE;
        #3;
        chk_all("idle spurious", 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
        tick();
        idle_inputs();
        tick();

        run_fill("basic", 16'h1A36, 16'h7777, 16'h1A30, 0, 1'b0, 1'b0);
        run_fill("wrap",  16'hFFF2, 16'h0002, 16'hFFF0, 0, 1'b0, 1'b1);
        run_fill("gap",   16'h4C8E, 16'h0000, 16'h4C80, 3, 1'b0, 1'b0);
        run_fill("drop",  16'h0B14, 16'h9990, 16'h0B10, 0, 1'b1, 1'b1);

        // Reset in the middle of a fill, with the miss line held high to test gating.
        for (int c = 0; c <= 5; c++) begin
            miss_detected     = (c == 0);
            miss_address      = 16'h2346;
            memory_data_valid = (c == 5);
            memory_data_out   = 16'h1111;
            tick();
        end
        miss_detected     = 1'b1;
        memory_data_valid = 1'b1;
        memory_data_out   = 16'h2222;
        #1;
        rst_n = 1'b0;
        #1;
        chk_all("async reset", 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
        tick();
        idle_inputs();
        #2;
        chk_all("held reset", 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
        tick();
        rst_n = 1'b1;
        #2;
        chk_all("after reset", 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
        tick();
        run_fill("restart", 16'h2346, 16'h0000, 16'h2340, 0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
